// File: rtl/writeback_arbiter_if.sv
// Bundle of the ALU, FPU, register-file and decode-query signals around writeback_arbiter.
// Optional q_data is present only when WB_FORWARD_EN is defined.
interface writeback_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    // Handshakes: the ALU result is taken at a posedge when alu_valid=1 and wb_stall=0;
    // otherwise the ALU keeps presenting it. An FPU result transfers at a posedge when
    // fpu_valid=1 and fpu_ready=1; the FPU holds it stable until then.
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic              alu_float;
    logic [DATA_W-1:0] alu_data;
    logic              wb_stall;
    logic              fpu_valid;
    logic              fpu_ready;
    logic [ADDR_W-1:0] fpu_reg;
    logic              fpu_float;
    logic [DATA_W-1:0] fpu_data;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic              float;
    logic [ADDR_W-1:0] q_reg;
    logic              q_float;
    logic              q_pending;
`ifdef WB_FORWARD_EN
    logic [DATA_W-1:0] q_data;
`endif

    modport slave (
        input  alu_valid, alu_reg, alu_float, alu_data,
        input  fpu_valid, fpu_reg, fpu_float, fpu_data,
        input  q_reg, q_float,
        output wb_stall, fpu_ready, writeReg, writeData, regWrite, float,
`ifdef WB_FORWARD_EN
        output q_data,
`endif
        output q_pending
    );

    modport master (
        output alu_valid, alu_reg, alu_float, alu_data,
        output fpu_valid, fpu_reg, fpu_float, fpu_data,
        output q_reg, q_float,
        input  wb_stall, fpu_ready, writeReg, writeData, regWrite, float,
`ifdef WB_FORWARD_EN
        input  q_data,
`endif
        input  q_pending
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered FPU results into one register-file write
// per cycle, with starvation relief for the FIFO. Define WB_FORWARD_EN to add q_data forwarding.
module writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst_n,
    writeback_arbiter_if.slave wb
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic              flt;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic              stall_q, stall_d;
    entry_t            out_q, out_d;
    logic              we_q, we_d;
    logic              push, pop, fifo_empty;
    logic [PTR_W-1:0]  slot;
    logic              pending;
`ifdef WB_FORWARD_EN
    logic [DATA_W-1:0] fwd;
`endif

    assign fifo_empty = (count_q == '0);
    // Ready is a pure function of the registered count, so a full FIFO refuses even in a pop cycle.
    assign wb.fpu_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push = wb.fpu_valid && wb.fpu_ready;

    always_comb begin
        pop      = 1'b0;
        stall_d  = 1'b0;
        starve_d = starve_q;
        out_d    = out_q;
        we_d     = 1'b0;
        if (wb.alu_valid && !stall_q) begin
            out_d = {wb.alu_float, wb.alu_reg, wb.alu_data};
            we_d  = 1'b1;
            if (fifo_empty) begin
                starve_d = '0;
            end else if (starve_q == ST_W'(STARVE_MAX - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end else if (!fifo_empty) begin
            out_d    = fifo_q[rd_ptr_q];
            we_d     = 1'b1;
            pop      = 1'b1;
            starve_d = '0;
        end
        // Integer r0 is hardwired: the slot is consumed but nothing is written.
        if (!out_d.flt && out_d.idx == '0) begin
            we_d = 1'b0;
        end
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            out_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            out_q    <= out_d;
            we_q     <= we_d;
        end
    end

    // Storage needs no reset; entries are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {wb.fpu_float, wb.fpu_reg, wb.fpu_data};
        end
    end

    // Walk head to tail so the youngest FIFO match wins, then let the output register override.
    always_comb begin
        pending = 1'b0;
        slot    = '0;
`ifdef WB_FORWARD_EN
        fwd     = '0;
`endif
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            slot = rd_ptr_q + PTR_W'(k);
            if (CNT_W'(k) < count_q && fifo_q[slot].idx == wb.q_reg && fifo_q[slot].flt == wb.q_float) begin
                pending = 1'b1;
`ifdef WB_FORWARD_EN
                fwd     = fifo_q[slot].data;
`endif
            end
        end
        if (we_q && out_q.idx == wb.q_reg && out_q.flt == wb.q_float) begin
            pending = 1'b1;
`ifdef WB_FORWARD_EN
            fwd     = out_q.data;
`endif
        end
    end

    assign wb.q_pending = pending;
`ifdef WB_FORWARD_EN
    assign wb.q_data    = fwd;
`endif
    assign wb.writeReg  = out_q.idx;
    assign wb.writeData = out_q.data;
    assign wb.float     = out_q.flt;
    assign wb.regWrite  = we_q;
    assign wb.wb_stall  = stall_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: table-driven ALU vectors, directed multi-cycle
// sequences, and a write-order scoreboard fed from an expected queue.
module tb_writeback_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int W      = ADDR_W + 1 + DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    writeback_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    bit mon_en = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic              f;
        logic [DATA_W-1:0] d;
        logic              exp_we;
    } alu_vec_t;

    function automatic logic [W-1:0] pack(input logic [ADDR_W-1:0] r, input logic f, input logic [DATA_W-1:0] d);
        return {r, f, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_float = 1'b0; bus.alu_data = '0;
        bus.fpu_valid = 1'b0; bus.fpu_reg = '0; bus.fpu_float = 1'b0; bus.fpu_data = '0;
    endtask

    task automatic drive_alu(input int r, input logic f, input logic [DATA_W-1:0] d);
        bus.alu_valid = 1'b1; bus.alu_reg = ADDR_W'(r); bus.alu_float = f; bus.alu_data = d;
    endtask

    task automatic drive_fpu(input int r, input logic f, input logic [DATA_W-1:0] d);
        bus.fpu_valid = 1'b1; bus.fpu_reg = ADDR_W'(r); bus.fpu_float = f; bus.fpu_data = d;
    endtask

    task automatic set_query(input int r, input logic f);
        bus.q_reg = ADDR_W'(r); bus.q_float = f;
        #1;
    endtask

    // Every register-file write must match the head of the expected queue.
    always @(posedge clk) begin
        #1;
        if (mon_en && bus.regWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got reg=%0d float=%0b data=0x%0h, required no write",
                         bus.writeReg, bus.float, bus.writeData);
            end else begin
                check("write_order", 64'(pack(bus.writeReg, bus.float, bus.writeData)), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        alu_vec_t vecs[5];
        logic [DATA_W-1:0] bd[4];
        logic [DATA_W-1:0] fd[5];
        logic [DATA_W-1:0] ad[8];
        logic [DATA_W-1:0] v1, v2;
        logic [15:0] trace;
        int idx, ncyc;
        logic stall_prev;

        idle_inputs();
        bus.q_reg = '0; bus.q_float = 1'b0;

        // ---------------- reset state
        #12;
        check("rst_regWrite", bus.regWrite, 0);
        check("rst_writeReg", bus.writeReg, 0);
        check("rst_writeData", bus.writeData, 0);
        check("rst_float", bus.float, 0);
        check("rst_wb_stall", bus.wb_stall, 0);
        check("rst_fpu_ready", bus.fpu_ready, 1);
        check("rst_q_pending", bus.q_pending, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ---------------- table-driven single ALU writes
        vecs[0] = '{6'd5,  1'b0, 32'h0000_000A, 1'b1};
        vecs[1] = '{6'd0,  1'b0, 32'h0000_0055, 1'b0};
        vecs[2] = '{6'd0,  1'b1, 32'h0000_0066, 1'b1};
        vecs[3] = '{6'd63, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{6'd33, 1'b0, 32'($urandom), 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive_alu(int'(vecs[i].r), vecs[i].f, vecs[i].d);
            if (vecs[i].exp_we) exp_q.push_back(pack(vecs[i].r, vecs[i].f, vecs[i].d));
            tick();
            check($sformatf("alu_we[%0d]", i), bus.regWrite, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("alu_reg[%0d]", i), bus.writeReg, vecs[i].r);
                check($sformatf("alu_data[%0d]", i), bus.writeData, vecs[i].d);
                check($sformatf("alu_float[%0d]", i), bus.float, vecs[i].f);
            end
            idle_inputs();
            tick();
            check($sformatf("alu_idle[%0d]", i), bus.regWrite, 0);
        end

        // ---------------- fill FIFO to full under ALU pressure, refused push while full
        for (int c = 0; c < 4; c++) bd[c] = DATA_W'($urandom_range(0, 32'hFFFF));
        for (int c = 0; c < 5; c++) fd[c] = 32'($urandom);
        for (int c = 0; c < 4; c++) exp_q.push_back(pack(ADDR_W'(10 + c), 1'b0, bd[c]));
        for (int c = 0; c < 5; c++) exp_q.push_back(pack(ADDR_W'(1 + c), 1'b1, fd[c]));
        for (int c = 0; c < 4; c++) begin
            drive_alu(10 + c, 1'b0, bd[c]);
            drive_fpu(1 + c, 1'b1, fd[c]);
            tick();
            check($sformatf("fill_ready[%0d]", c), bus.fpu_ready, (c < 3) ? 1 : 0);
            check($sformatf("fill_stall[%0d]", c), bus.wb_stall, (c == 3) ? 1 : 0);
        end
        idle_inputs();
        drive_fpu(5, 1'b1, fd[4]);
        tick();
        check("full_pop_we", bus.regWrite, 1);
        check("full_pop_ready", bus.fpu_ready, 1);
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("drain_we[%0d]", c), bus.regWrite, 1);
        end
        tick();
        check("drain_done", bus.regWrite, 0);

        // ---------------- starvation: ALU every cycle, two FPU entries, re-presentation on stall
        for (int i = 0; i < 8; i++) ad[i] = 32'($urandom);
        v1 = 32'($urandom);
        v2 = 32'($urandom);
        for (int i = 0; i < 4; i++) exp_q.push_back(pack(ADDR_W'(40 + i), 1'b0, ad[i]));
        exp_q.push_back(pack(ADDR_W'(50), 1'b1, v1));
        for (int i = 4; i < 7; i++) exp_q.push_back(pack(ADDR_W'(40 + i), 1'b0, ad[i]));
        exp_q.push_back(pack(ADDR_W'(51), 1'b1, v2));
        exp_q.push_back(pack(ADDR_W'(47), 1'b0, ad[7]));
        idx = 0; ncyc = 0; stall_prev = 1'b0; trace = '0;
        for (int cyc = 0; cyc < 16 && idx < 8; cyc++) begin
            drive_alu(40 + idx, 1'b0, ad[idx]);
            if (cyc < 2) drive_fpu(50 + cyc, 1'b1, (cyc == 0) ? v1 : v2);
            else bus.fpu_valid = 1'b0;
            tick();
            if (!stall_prev) idx++;
            trace[cyc] = bus.wb_stall;
            stall_prev = bus.wb_stall;
            ncyc = cyc + 1;
        end
        idle_inputs();
        check("starve_accepted", idx, 8);
        check("starve_cycles", ncyc, 10);
        check("stall_trace", trace, 16'h0088);
        tick();

        // ---------------- register 0 through the FIFO
        v1 = 32'($urandom);
        v2 = 32'($urandom);
        exp_q.push_back(pack(ADDR_W'(9), 1'b1, v1));
        exp_q.push_back(pack(ADDR_W'(0), 1'b1, v2));
        drive_fpu(0, 1'b0, 32'hDEAD_0000);
        tick();
        check("r0_push_we", bus.regWrite, 0);
        drive_fpu(9, 1'b1, v1);
        tick();
        check("r0_int_slot_we", bus.regWrite, 0);
        drive_fpu(0, 1'b1, v2);
        tick();
        check("r9_we", bus.regWrite, 1);
        idle_inputs();
        tick();
        check("f0_we", bus.regWrite, 1);
        check("f0_float", bus.float, 1);
        check("f0_reg", bus.writeReg, 0);
        tick();
        check("r0_idle", bus.regWrite, 0);

        // ---------------- q_pending lifetime of a single FIFO write to float r7
        v1 = 32'($urandom);
        exp_q.push_back(pack(ADDR_W'(7), 1'b1, v1));
        drive_fpu(7, 1'b1, v1);
        set_query(7, 1'b1);
        check("q_before_push", bus.q_pending, 0);
        tick();
        bus.fpu_valid = 1'b0;
        check("q_in_fifo", bus.q_pending, 1);
        set_query(7, 1'b0);
        check("q_wrong_bank", bus.q_pending, 0);
        set_query(7, 1'b1);
        tick();
        check("q_out_we", bus.regWrite, 1);
        check("q_on_output", bus.q_pending, 1);
        tick();
        check("q_after_write", bus.q_pending, 0);

        // ---------------- two queued writes to float r7 held in the FIFO by ALU traffic
        v1 = 32'($urandom);
        v2 = 32'($urandom);
        bd[0] = 32'($urandom);
        exp_q.push_back(pack(ADDR_W'(20), 1'b0, bd[0]));
        exp_q.push_back(pack(ADDR_W'(21), 1'b0, bd[0] ^ 32'h1));
        exp_q.push_back(pack(ADDR_W'(22), 1'b0, bd[0] ^ 32'h2));
        exp_q.push_back(pack(ADDR_W'(7), 1'b1, v1));
        exp_q.push_back(pack(ADDR_W'(7), 1'b1, v2));
        drive_alu(20, 1'b0, bd[0]);
        drive_fpu(7, 1'b1, v1);
        set_query(20, 1'b0);
        check("q_same_cycle_alu", bus.q_pending, 0);
        set_query(7, 1'b1);
        tick();
        drive_alu(21, 1'b0, bd[0] ^ 32'h1);
        drive_fpu(7, 1'b1, v2);
        tick();
        bus.fpu_valid = 1'b0;
        check("q_two_queued", bus.q_pending, 1);
`ifdef WB_FORWARD_EN
        check("q_data_younger", bus.q_data, v2);
`endif
        drive_alu(22, 1'b0, bd[0] ^ 32'h2);
        tick();
        idle_inputs();
        set_query(22, 1'b0);
        check("q_alu_output", bus.q_pending, 1);
        set_query(7, 1'b1);
        tick();
        tick();
        tick();
        check("q_r7_drained", bus.q_pending, 0);

        // ---------------- reset mid-run with three FIFO entries
        for (int c = 0; c < 3; c++) begin
            bd[c] = 32'($urandom);
            exp_q.push_back(pack(ADDR_W'(30 + c), 1'b0, bd[c]));
        end
        for (int c = 0; c < 3; c++) begin
            drive_alu(30 + c, 1'b0, bd[c]);
            drive_fpu(1 + c, 1'b1, 32'($urandom));
            tick();
        end
        idle_inputs();
        set_query(2, 1'b1);
        check("pre_rst_pending", bus.q_pending, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_regWrite", bus.regWrite, 0);
        check("mid_rst_writeReg", bus.writeReg, 0);
        check("mid_rst_writeData", bus.writeData, 0);
        check("mid_rst_float", bus.float, 0);
        check("mid_rst_wb_stall", bus.wb_stall, 0);
        check("mid_rst_fpu_ready", bus.fpu_ready, 1);
        check("mid_rst_q_pending", bus.q_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("post_rst_we[%0d]", c), bus.regWrite, 0);
        end

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
